i2c_frame_tx: RTL

Serial frame transmitter for the team's 11-bit I2C-style link. It accepts 9-bit words over a valid/ready handshake and serializes each one as a start bit (0), 9 data bits MSB first, and a stop bit (1) on a single line that idles high. Output framing matches the receive-side frame decoder: the first bit after start is data[8]. A one-word holding register allows back-to-back frames with no idle gap.

---
 rtl/i2c_frame_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/i2c_frame_tx.sv
// i2c_frame_tx: serial frame transmitter for the 11-bit I2C-style link.
//
// Each accepted word goes out as a start bit (0), DATA_BITS data bits
// MSB first, and a stop bit (1). The line idles high. A one-word holding
// register lets the next word queue up during a frame, so frames can go
// out back to back with no idle gap.
//
// Handshake: a word is accepted on a rising edge where TX_VALID and
// TX_READY are both high. TX_READY is high exactly when the holding
// register is empty. TX_DATA is sampled only on an accept edge.
// TX_VALID may stay high; each accept consumes one word.
//
// Ports:
//   SYNCED_CLK   in   sole clock, rising edge
//   RST          in   synchronous active-high reset
//   TX_DATA      in   [DATA_BITS-1:0] word to send
//   TX_VALID     in   TX_DATA is valid
//   TX_READY     out  holding register empty
//   TX_LINE      out  registered serial line, idle 1
//   BUSY         out  a frame is on the line (start through stop)
//   FRAME_DONE   out  one-cycle pulse after a stop bit completes
//   debug_state  out  current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
module i2c_frame_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 9
) (
    input  logic                 SYNCED_CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 TX_LINE,
    output logic                 BUSY,
    output logic                 FRAME_DONE,
    output logic [1:0]           debug_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q;
    logic                 line_q, line_d;
    logic                 done_q, done_d;

    logic                 bit_end;
    logic                 accept;
    logic                 load;
    logic                 frame_end;

    // The divider sits at 0 in IDLE, so every bit period starts from 0.
    assign bit_end = (div_q == DIV_LAST);
    // An accept can never coincide with a load: load needs a full
    // holding register, accept needs an empty one.
    assign accept  = TX_VALID && !hold_full_q;

    // State register plus datapath registers.
    always_ff @(posedge SYNCED_CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            div_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            line_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            done_q  <= done_d;
            if (accept) begin
                hold_q      <= TX_DATA;
                hold_full_q <= 1'b1;
            end else if (load) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        load      = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = IDX_TOP;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == '0) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    frame_end = 1'b1;
                    // A queued word starts immediately, no idle cycle.
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            div_d = bit_end ? '0 : div_q + 1'b1;
        end
        if (load) begin
            shift_d = hold_q;
        end
    end

    // Output logic: the line is registered, so its next value is derived
    // from the next state so that it changes on the same edge as the FSM.
    always_comb begin
        line_d = 1'b1;
        done_d = frame_end;
        unique case (state_d)
            IDLE:    line_d = 1'b1;
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[idx_d];
            STOP:    line_d = 1'b1;
            default: line_d = 1'b1;
        endcase
    end

    assign TX_READY    = !hold_full_q;
    assign TX_LINE     = line_q;
    assign BUSY        = (state_q != IDLE);
    assign FRAME_DONE  = done_q;
    assign debug_state = state_q;

endmodule
